// File: rtl/rv32_alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : rv32_alu_pkg                                                   |
// | Purpose : Function encodings, FSM state type and op-class decode for the |
// |           rv32_alu_mdu execute unit.                                     |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package rv32_alu_pkg;

  // func = {class[1:0], funct3[2:0]}
  localparam logic [4:0] FUNC_ADD    = 5'b00_000;
  localparam logic [4:0] FUNC_SLL    = 5'b00_001;
  localparam logic [4:0] FUNC_SLT    = 5'b00_010;
  localparam logic [4:0] FUNC_SLTU   = 5'b00_011;
  localparam logic [4:0] FUNC_XOR    = 5'b00_100;
  localparam logic [4:0] FUNC_SRL    = 5'b00_101;
  localparam logic [4:0] FUNC_OR     = 5'b00_110;
  localparam logic [4:0] FUNC_AND    = 5'b00_111;
  localparam logic [4:0] FUNC_SUB    = 5'b01_000;
  localparam logic [4:0] FUNC_SRA    = 5'b01_101;
  localparam logic [4:0] FUNC_MUL    = 5'b10_000;
  localparam logic [4:0] FUNC_MULH   = 5'b10_001;
  localparam logic [4:0] FUNC_MULHSU = 5'b10_010;
  localparam logic [4:0] FUNC_MULHU  = 5'b10_011;
  localparam logic [4:0] FUNC_DIV    = 5'b10_100;
  localparam logic [4:0] FUNC_DIVU   = 5'b10_101;
  localparam logic [4:0] FUNC_REM    = 5'b10_110;
  localparam logic [4:0] FUNC_REMU   = 5'b10_111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed_a;
    logic is_signed_b;
    logic want_high;
    logic want_rem;
  } op_dec_t;

  // Classify an op code; anything outside the M class decodes to all-zero.
  function automatic op_dec_t decode_op(input logic [4:0] func);
    op_dec_t d;
    d = '0;
    case (func)
      FUNC_MUL:    d.is_mul = 1'b1;
      FUNC_MULH:   begin d.is_mul = 1'b1; d.is_signed_a = 1'b1; d.is_signed_b = 1'b1; d.want_high = 1'b1; end
      FUNC_MULHSU: begin d.is_mul = 1'b1; d.is_signed_a = 1'b1; d.want_high = 1'b1; end
      FUNC_MULHU:  begin d.is_mul = 1'b1; d.want_high = 1'b1; end
      FUNC_DIV:    begin d.is_div = 1'b1; d.is_signed_a = 1'b1; d.is_signed_b = 1'b1; end
      FUNC_DIVU:   d.is_div = 1'b1;
      FUNC_REM:    begin d.is_div = 1'b1; d.is_signed_a = 1'b1; d.is_signed_b = 1'b1; d.want_rem = 1'b1; end
      FUNC_REMU:   begin d.is_div = 1'b1; d.want_rem = 1'b1; end
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_alu_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rv32_alu_divider                                               |
// | Purpose : Iterative restoring divider on operand magnitudes. One step    |
// |           per step_i pulse; sign correction folded into the last step.   |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rv32_alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, done_q, done_d;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_fit;
  logic [XLEN-1:0] w_quo_n, w_rem_n;

  // Trial subtraction: shift next dividend bit into the partial remainder.
  assign w_shift = {rem_q, quo_q[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, dvs_q};
  assign w_fit   = ~w_diff[XLEN];
  assign w_rem_n = w_fit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_n = {quo_q[XLEN-2:0], w_fit};

  // Next-state: load magnitudes on start, iterate on step, fix signs on last.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = done_q;
    if (start_i) begin
      quo_d     = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
      dvs_d     = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
      rem_d     = '0;
      neg_quo_d = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      neg_rem_d = signed_i & dividend_i[XLEN-1];
      done_d    = 1'b0;
    end else if (step_i) begin
      quo_d = w_quo_n;
      rem_d = w_rem_n;
      if (last_i) begin
        quo_d  = neg_quo_q ? -w_quo_n : w_quo_n;
        rem_d  = neg_rem_q ? -w_rem_n : w_rem_n;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/rv32_alu_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rv32_alu_mdu                                                   |
// | Purpose : RV32I ALU plus RV32M multiply/divide with valid/ready on both  |
// |           sides; shift-add multiplier here, divider in a sub-module.     |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rv32_alu_mdu
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      func_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              mul_hi_q, mul_hi_d, mul_sb_q, mul_sb_d;
  logic              want_rem_q, want_rem_d, div_sel_q, div_sel_d;

  op_dec_t           w_dec;
  logic              w_accept, w_last, w_div_special;
  logic [CW-1:0]     w_sh;
  logic [XLEN-1:0]   w_alu, w_special, w_div_res;
  logic [2*XLEN-1:0] w_addend, w_mul_sum;
  logic              div_start, div_step, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign w_dec      = decode_op(func_i);
  assign in_ready_o = !flush_i && ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready_i));
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_last     = (cnt_q == '0);
  assign w_sh       = op_b_i[CW-1:0];

  // Single-cycle datapath; unknown codes pass op_a through.
  always_comb begin
    w_alu = op_a_i;
    case (func_i)
      FUNC_ADD:  w_alu = op_a_i + op_b_i;
      FUNC_SLL:  w_alu = op_a_i << w_sh;
      FUNC_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      FUNC_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
      FUNC_XOR:  w_alu = op_a_i ^ op_b_i;
      FUNC_SRL:  w_alu = op_a_i >> w_sh;
      FUNC_OR:   w_alu = op_a_i | op_b_i;
      FUNC_AND:  w_alu = op_a_i & op_b_i;
      FUNC_SUB:  w_alu = op_a_i - op_b_i;
      FUNC_SRA:  w_alu = $signed(op_a_i) >>> w_sh;
      default:   w_alu = op_a_i;
    endcase
  end

  // Divide special cases bypass the divider: x/0 and MIN/-1.
  always_comb begin
    w_div_special = 1'b0;
    w_special     = op_a_i;
    if (op_b_i == '0) begin
      w_div_special = w_dec.is_div;
      w_special     = w_dec.want_rem ? op_a_i : '1;
    end else if (w_dec.is_signed_a && op_a_i == MIN_NEG && op_b_i == '1) begin
      w_div_special = w_dec.is_div;
      w_special     = w_dec.want_rem ? '0 : op_a_i;
    end
  end

  // Shift-add step; the sign bit of a signed multiplier carries negative weight.
  assign w_addend  = mplier_q[0] ? mcand_q : '0;
  assign w_mul_sum = (w_last && mul_sb_q) ? acc_q - w_addend : acc_q + w_addend;

  // FSM next-state, iteration control and operand capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_hi_d   = mul_hi_q;
    mul_sb_d   = mul_sb_q;
    want_rem_d = want_rem_q;
    div_sel_d  = div_sel_q;
    div_start  = 1'b0;
    div_step   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_MUL: begin
        acc_d    = w_mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (w_last) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = mul_hi_q ? w_mul_sum[2*XLEN-1:XLEN] : w_mul_sum[XLEN-1:0];
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (w_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      mul_hi_d   = w_dec.want_high;
      mul_sb_d   = w_dec.is_signed_b;
      want_rem_d = w_dec.want_rem;
      div_sel_d  = 1'b0;
      if (w_dec.is_mul) begin
        state_d  = ST_MUL;
        cnt_d    = CW'(XLEN-1);
        acc_d    = '0;
        mcand_d  = {{XLEN{op_a_i[XLEN-1] & w_dec.is_signed_a}}, op_a_i};
        mplier_d = op_b_i;
      end else if (w_dec.is_div && !w_div_special) begin
        state_d   = ST_DIV;
        cnt_d     = CW'(XLEN-1);
        div_start = 1'b1;
        div_sel_d = 1'b1;
      end else begin
        state_d  = ST_DONE;
        result_d = w_dec.is_div ? w_special : w_alu;
      end
    end

    if (flush_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      div_sel_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mul_hi_q   <= 1'b0;
      mul_sb_q   <= 1'b0;
      want_rem_q <= 1'b0;
      div_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_hi_q   <= mul_hi_d;
      mul_sb_q   <= mul_sb_d;
      want_rem_q <= want_rem_d;
      div_sel_q  <= div_sel_d;
    end
  end

  rv32_alu_divider #(.XLEN(XLEN)) u_divider (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (div_start),
    .step_i     (div_step),
    .last_i     (w_last),
    .signed_i   (w_dec.is_signed_a),
    .dividend_i (op_a_i),
    .divisor_i  (op_b_i),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .done_o     (div_done)
  );

  assign w_div_res   = want_rem_q ? div_rem : div_quo;
  assign result_o    = (div_sel_q && div_done) ? w_div_res : result_q;
  assign out_valid_o = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rv32_alu_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rv32_alu_mdu                                                |
// | Purpose : Scoreboard bench for rv32_alu_mdu: directed corner cases and   |
// |           random ops against an arithmetic reference model.              |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rv32_alu_mdu;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  func = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;
  exp_t sb[$];

  rv32_alu_mdu #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .func_i      (func),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic per RV32I/M semantics.
  function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pa, pb, p;
    logic [31:0] q, r;
    int sa, sbv, sh;
    sa = $signed(a); sbv = $signed(b); sh = int'(b[4:0]);
    case (f[4:3])
      2'b00: case (f[2:0])
        3'd0: return a + b;
        3'd1: return a << sh;
        3'd2: return (sa < sbv) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return a >> sh;
        3'd6: return a | b;
        default: return a & b;
      endcase
      2'b01: begin
        if (f[2:0] == 3'd0) return a - b;
        if (f[2:0] == 3'd5) return 32'(sa >>> sh);
        return a;
      end
      2'b10: begin
        if (!f[2]) begin
          pa = (f[1:0] == 2'd1 || f[1:0] == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
          pb = (f[1:0] == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
          p  = pa * pb;
          return (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
        else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 32'd0; end
        else if (!f[0]) begin q = 32'(sa / sbv); r = 32'(sa % sbv); end
        else begin q = a / b; r = a % b; end
        return f[1] ? r : q;
      end
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[4:3] != 2'b10) return 1;
    if (!f[2]) return 33;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present an op until accepted; expected response is queued at acceptance.
  task automatic drive_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_l, input string nm);
    exp_t e;
    in_valid = 1'b1; func = f; op_a = a; op_b = b;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (in_ready) begin
        e.res = exp_r; e.acc = cyc; e.lat = exp_l; e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; func = 5'($urandom); op_a = $urandom; op_b = $urandom;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        return;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    n_checks++; n_fail++;
    $display("FAIL %s_accept: not accepted within 200 cycles", nm);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  logic        first_done = 1'b0, stall_prev = 1'b0;
  logic [31:0] stall_res = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      first_done = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (flush) first_done = 1'b0;
      if (sb.size() == 0) begin
        if (!flush) check("no_stale_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (!first_done) begin
          check({sb[0].nm, "_latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          first_done = 1'b1;
        end
        if (stall_prev) check({sb[0].nm, "_hold"}, result, stall_res);
        if (!out_ready) check({sb[0].nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        else begin
          check(sb[0].nm, result, sb[0].res);
          void'(sb.pop_front());
          first_done = 1'b0;
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      stall_res  = result;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0]  f;
  logic [31:0] a, b;
  logic [4:0]  codes [20];

  initial begin
    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
              5'b00111, 5'b01000, 5'b01101, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
              5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b01011, 5'b11010};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Directed corner cases with hand-derived expectations.
    drive_op(5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, "slt");
    drive_op(5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "sltu");
    drive_op(5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, "sra");
    drive_op(5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, "srl");
    drive_op(5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    drive_op(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    drive_op(5'b10100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
    drive_op(5'b10110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
    drive_op(5'b10100, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
    drive_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    drive_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    idle(2);

    // Back-pressure: hold an ADD result, then release with a new ADD waiting.
    out_ready = 1'b0;
    drive_op(5'b00000, 32'd10, 32'd20, 32'd30, 1, "add_bp");
    idle(5);
    out_ready = 1'b1; in_valid = 1'b1; func = 5'b00000; op_a = 32'd100; op_b = 32'd1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    drive_op(5'b00000, 32'd100, 32'd1, 32'd101, 1, "add_after_bp");
    idle(2);

    // Flush mid-DIVU: its result must never appear.
    drive_op(5'b10101, 32'd1000, 32'd7, 32'd142, 33, "divu_flushed");
    repeat (9) begin @(posedge clk); #1; end
    out_ready = 1'b0; flush = 1'b1; sb.delete();
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    drive_op(5'b00000, 32'd2, 32'd3, 32'd5, 1, "add_after_flush");
    idle(40);

    // Reset pulse mid-MUL: same recovery.
    drive_op(5'b10000, 32'd3, 32'd5, 32'd15, 33, "mul_reset");
    repeat (12) begin @(posedge clk); #1; end
    rst_n = 1'b0; sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_mul_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_mul_in_ready", 32'(in_ready), 32'd1);
    drive_op(5'b00000, 32'd2, 32'd3, 32'd5, 1, "add_after_reset");
    idle(40);

    // Random stream with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      f = codes[$urandom_range(0, 19)];
      a = pick_operand();
      b = pick_operand();
      drive_op(f, a, b, ref_result(f, a, b), ref_lat(f, a, b), $sformatf("rand%0d_f%02h", i, f));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Drain outstanding results.
    rand_ready = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
